// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register map, bit positions and FSM encoding for the UART receive controller
package uart_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int unsigned STS_EMPTY = 0;
  localparam int unsigned STS_THR   = 1;
  localparam int unsigned STS_BUSY  = 2;
  localparam int unsigned STS_OV    = 3;
  localparam int unsigned STS_PE    = 4;
  localparam int unsigned STS_FRE   = 5;

  localparam int unsigned CTRL_W = 7;

  // Field order mirrors the CTRL bit layout, MSB first (bit6 ie_err ... bit0 rx_en).
  typedef struct packed {
    logic       ie_err;
    logic       ie_thr;
    logic [1:0] thr_val;
    logic       parity_type;
    logic       parity_en;
    logic       rx_en;
  } ctrl_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_POP     = 3'd1,
    ST_WAIT_WR = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERR     = 3'd4
  } rx_fsm_e;

endpackage

// File: rtl/uart_rx_irq.sv
// rtl/uart_rx_irq.sv - sticky error flags with W1C clear and registered interrupt
module uart_rx_irq
  import uart_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic rx_ov,
  input  logic rx_thr,
  input  logic pe_set,
  input  logic fre_set,
  input  logic w1c_en,
  input  logic w1c_ov,
  input  logic w1c_pe,
  input  logic w1c_fre,
  input  logic ie_thr,
  input  logic ie_err,
  output logic ov_sticky,
  output logic pe_sticky,
  output logic fre_sticky,
  output logic irq
);

  // A set in the same cycle as its clear takes priority.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ov_sticky  <= 1'b0;
      pe_sticky  <= 1'b0;
      fre_sticky <= 1'b0;
      irq        <= 1'b0;
    end else begin
      ov_sticky  <= rx_ov   | (ov_sticky  & ~(w1c_en & w1c_ov));
      pe_sticky  <= pe_set  | (pe_sticky  & ~(w1c_en & w1c_pe));
      fre_sticky <= fre_set | (fre_sticky & ~(w1c_en & w1c_fre));
      irq        <= (ie_thr & rx_thr) | (ie_err & (ov_sticky | pe_sticky | fre_sticky));
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - APB register front-end and FIFO pop FSM for the UART receiver
module uart_rx_ctrl
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        rx_en,
  output logic        parity_en,
  output logic        parity_type,
  output logic [1:0]  rx_thr_val,
  output logic        read_en,
  input  logic [9:0]  data_out,
  input  logic        rx_fre,
  input  logic        rx_pe,
  input  logic        rx_ov,
  input  logic        rx_thr,
  input  logic        rx_bclk_en,
  input  logic        rx_fifo_empty,
  input  logic        rx_fifo_wr,
  output logic        irq
);

  rx_fsm_e     state, state_nxt;
  ctrl_t       ctrl;
  logic        par_en_q, par_type_q;
  logic [1:0]  reg_sel;
  logic        reg_access, ctrl_wr, status_wr;
  logic        ov_sticky, pe_sticky, fre_sticky;
  logic [31:0] status_word, data_word;
  logic        unused_bits;

  assign reg_sel    = paddr[3:2];
  assign reg_access = resetn && psel && penable && (state == ST_IDLE) &&
                      ((reg_sel == REG_CTRL) || (reg_sel == REG_STATUS));
  assign ctrl_wr    = reg_access && pwrite && (reg_sel == REG_CTRL);
  assign status_wr  = reg_access && pwrite && (reg_sel == REG_STATUS);
  assign data_word  = {22'd0, rx_pe, rx_fre, data_out[7:0]};
  assign unused_bits = ^{paddr[1:0], pwdata[31:CTRL_W], data_out[9:8]};

  always_comb begin
    status_word            = '0;
    status_word[STS_EMPTY] = rx_fifo_empty;
    status_word[STS_THR]   = rx_thr;
    status_word[STS_BUSY]  = rx_bclk_en;
    status_word[STS_OV]    = ov_sticky;
    status_word[STS_PE]    = pe_sticky;
    status_word[STS_FRE]   = fre_sticky;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // DATA and unmapped accesses are decoded in the setup phase so a clean pop completes on the 2nd access cycle.
  always_comb begin
    state_nxt = state;
    if (!psel) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!penable && ((reg_sel == REG_DATA) || (reg_sel == REG_RSVD))) begin
            if (pwrite || (reg_sel == REG_RSVD) || rx_fifo_empty) state_nxt = ST_ERR;
            else if (rx_fifo_wr)                                  state_nxt = ST_WAIT_WR;
            else                                                  state_nxt = ST_POP;
          end
        end
        ST_WAIT_WR: if (!rx_fifo_wr) state_nxt = ST_POP;
        ST_POP:     state_nxt = ST_DONE;
        ST_DONE:    state_nxt = ST_IDLE;
        ST_ERR:     state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    read_en = 1'b0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    case (state)
      ST_IDLE: begin
        if (reg_access) begin
          pready = 1'b1;
          if (!pwrite) prdata = (reg_sel == REG_CTRL) ? {25'd0, ctrl} : status_word;
        end
      end
      ST_POP:  read_en = psel;
      ST_DONE: begin
        pready = psel;
        if (psel) prdata = data_word;
      end
      ST_ERR: begin
        pready  = psel;
        pslverr = psel;
      end
      default: ;
    endcase
  end

  // Parity settings are only handed to the receiver while it is not mid-character.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl       <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl <= ctrl_t'(pwdata[CTRL_W-1:0]);
      if (!rx_bclk_en) begin
        par_en_q   <= ctrl.parity_en;
        par_type_q <= ctrl.parity_type;
      end
    end
  end

  assign rx_en       = ctrl.rx_en;
  assign rx_thr_val  = ctrl.thr_val;
  assign parity_en   = par_en_q;
  assign parity_type = par_type_q;

  uart_rx_irq u_irq (
    .clk        (clk),
    .resetn     (resetn),
    .rx_ov      (rx_ov),
    .rx_thr     (rx_thr),
    .pe_set     ((state == ST_DONE) && psel && rx_pe),
    .fre_set    ((state == ST_DONE) && psel && rx_fre),
    .w1c_en     (status_wr),
    .w1c_ov     (pwdata[STS_OV]),
    .w1c_pe     (pwdata[STS_PE]),
    .w1c_fre    (pwdata[STS_FRE]),
    .ie_thr     (ctrl.ie_thr),
    .ie_err     (ctrl.ie_err),
    .ov_sticky  (ov_sticky),
    .pe_sticky  (pe_sticky),
    .fre_sticky (fre_sticky),
    .irq        (irq)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        psel, penable, pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        rx_en, parity_en, parity_type, read_en, irq;
  logic [1:0]  rx_thr_val;
  logic [9:0]  data_out;
  logic        rx_fre, rx_pe, rx_ov, rx_thr, rx_bclk_en, rx_fifo_empty, rx_fifo_wr;

  int n_checks = 0;
  int n_fail   = 0;
  int re_total = 0;
  int re_consec = 0;
  logic re_prev = 1'b0;

  logic [31:0] rd;
  logic        err;
  int          ncyc, re_at;

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .clk(clk), .resetn(resetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .rx_en(rx_en), .parity_en(parity_en), .parity_type(parity_type), .rx_thr_val(rx_thr_val),
    .read_en(read_en), .data_out(data_out), .rx_fre(rx_fre), .rx_pe(rx_pe), .rx_ov(rx_ov),
    .rx_thr(rx_thr), .rx_bclk_en(rx_bclk_en), .rx_fifo_empty(rx_fifo_empty),
    .rx_fifo_wr(rx_fifo_wr), .irq(irq)
  );

  always @(negedge clk) begin
    if (read_en) begin
      re_total++;
      if (re_prev) re_consec++;
    end
    re_prev = read_en;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One APB transfer; rx_fifo_wr is held high for wr_len cycles counting the setup cycle.
  task automatic apb_xfer(input logic wr, input logic [3:0] a, input logic [31:0] d, input int wr_len,
                          output logic [31:0] rdata, output logic serr, output int cyc, output int re_cyc);
    rdata = '0; serr = 1'b0; cyc = 99; re_cyc = 0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    rx_fifo_wr = (wr_len > 0);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      penable = 1'b1;
      rx_fifo_wr = (k < wr_len);
      @(negedge clk);
      if (read_en && re_cyc == 0) re_cyc = k;
      if (pready) begin
        cyc = k; rdata = prdata; serr = pslverr;
        break;
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rx_fifo_wr = 1'b0;
  endtask

  task automatic reg_write(input string tag, input logic [3:0] a, input logic [31:0] d);
    apb_xfer(1'b1, a, d, 0, rd, err, ncyc, re_at);
    check_eq({tag, "_cyc"}, 32'(ncyc), 32'd1);
  endtask

  task automatic reg_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
    apb_xfer(1'b0, a, 32'd0, 0, rd, err, ncyc, re_at);
    check_eq(tag, rd, exp);
  endtask

  initial begin
    resetn = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 4'h0; pwdata = '0;
    data_out = '0; rx_fre = 0; rx_pe = 0; rx_ov = 0; rx_thr = 0; rx_bclk_en = 0;
    rx_fifo_empty = 1'b1; rx_fifo_wr = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ctl", 32'({pready, pslverr, read_en, rx_en, parity_en, parity_type, rx_thr_val, irq}), 32'd0);
    check_eq("rst_prdata", prdata, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;

    reg_read("ctrl_rst", 4'h0, 32'h0);
    check_eq("ctrl_rd_cyc", 32'(ncyc), 32'd1);
    reg_read("status_rst", 4'h4, 32'h1);

    // CTRL write while the receiver is busy
    rx_bclk_en = 1'b1;
    reg_write("ctrl_wr", 4'h0, 32'h1F);
    check_eq("ctrl_wr_err", 32'(err), 32'd0);
    check_eq("cfg_next", 32'({rx_en, rx_thr_val, parity_en, parity_type}), 32'b11100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("cfg_held", 32'({rx_en, rx_thr_val, parity_en, parity_type}), 32'b11100);
    @(posedge clk); #1 rx_bclk_en = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("cfg_par", 32'({rx_en, rx_thr_val, parity_en, parity_type}), 32'b11111);
    reg_read("ctrl_rb", 4'h0, 32'h1F);

    // Clean pop
    rx_fifo_empty = 1'b0; data_out = 10'h0A5;
    apb_xfer(1'b0, 4'h8, 32'd0, 0, rd, err, ncyc, re_at);
    check_eq("pop_data", rd, 32'h0A5);
    check_eq("pop_err", 32'(err), 32'd0);
    check_eq("pop_cyc", 32'(ncyc), 32'd2);
    check_eq("pop_re_at", 32'(re_at), 32'd1);

    data_out = 10'h3C3; rx_fre = 1'b1;
    apb_xfer(1'b0, 4'h8, 32'd0, 0, rd, err, ncyc, re_at);
    check_eq("pop_fre", rd, 32'h1C3);
    rx_fre = 1'b0;
    reg_read("status_fre", 4'h4, 32'h20);
    reg_write("w1c_all", 4'h4, 32'h38);
    reg_read("status_clr", 4'h4, 32'h00);

    // Error responses
    rx_fifo_empty = 1'b1;
    apb_xfer(1'b0, 4'h8, 32'd0, 0, rd, err, ncyc, re_at);
    check_eq("empty_err", 32'(err), 32'd1);
    check_eq("empty_data", rd, 32'd0);
    check_eq("empty_cyc", 32'(ncyc), 32'd1);
    check_eq("empty_re", 32'(re_at), 32'd0);
    rx_fifo_empty = 1'b0;
    apb_xfer(1'b1, 4'h8, 32'h55, 0, rd, err, ncyc, re_at);
    check_eq("data_wr_err", 32'(err), 32'd1);
    apb_xfer(1'b0, 4'hC, 32'd0, 0, rd, err, ncyc, re_at);
    check_eq("rsvd_err", 32'(err), 32'd1);
    check_eq("rsvd_cyc", 32'(ncyc), 32'd1);

    // Pop held off by a receiver FIFO write
    data_out = 10'h17E;
    apb_xfer(1'b0, 4'h8, 32'd0, 3, rd, err, ncyc, re_at);
    check_eq("wait_re_at", 32'(re_at), 32'd4);
    check_eq("wait_cyc", 32'(ncyc), 32'd5);
    check_eq("wait_data", rd, 32'h7E);

    // Overflow set racing its W1C clear
    reg_write("ctrl_ie_err", 4'h0, 32'h40);
    check_eq("irq_idle", 32'(irq), 32'd0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h4; pwdata = 32'h08;
    @(posedge clk); #1;
    penable = 1'b1; rx_ov = 1'b1;
    @(negedge clk);
    check_eq("ov_w1c_rdy", 32'(pready), 32'd1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rx_ov = 1'b0;
    check_eq("ov_irq_lat", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check_eq("ov_irq", 32'(irq), 32'd1);
    reg_read("status_ov", 4'h4, 32'h08);
    reg_write("w1c_ov", 4'h4, 32'h08);
    @(posedge clk); #1;
    check_eq("ov_irq_clr", 32'(irq), 32'd0);

    // Parity error entry, then W1C of pe_sticky
    rx_pe = 1'b1; data_out = 10'h05A;
    apb_xfer(1'b0, 4'h8, 32'd0, 0, rd, err, ncyc, re_at);
    check_eq("pop_pe", rd, 32'h25A);
    rx_pe = 1'b0;
    reg_read("status_pe", 4'h4, 32'h10);
    check_eq("pe_irq", 32'(irq), 32'd1);
    reg_write("w1c_pe", 4'h4, 32'h10);
    @(posedge clk); #1;
    reg_read("status_pe_clr", 4'h4, 32'h00);
    check_eq("pe_irq_clr", 32'(irq), 32'd0);

    // Threshold interrupt
    rx_thr = 1'b1;
    reg_write("ctrl_ie_thr", 4'h0, 32'h20);
    @(posedge clk); #1;
    check_eq("thr_irq", 32'(irq), 32'd1);
    reg_read("status_thr", 4'h4, 32'h02);
    rx_thr = 1'b0;

    // Unselected bus stays quiet
    penable = 1'b1; paddr = 4'h0;
    repeat (2) @(negedge clk);
    check_eq("nosel_quiet", 32'({pready, read_en}), 32'd0);
    penable = 1'b0;

    // Reset while in POP
    reg_write("ctrl_cfg", 4'h0, 32'h1F);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h8;
    @(posedge clk); #1;
    penable = 1'b1;
    #1 check_eq("abort_pop_re", 32'(read_en), 32'd1);
    #1 resetn = 1'b0;
    #1 check_eq("abort_out", 32'({read_en, pready, pslverr}), 32'd0);
    repeat (2) @(negedge clk);
    check_eq("abort_cfg", 32'({read_en, pready, rx_en, rx_thr_val, parity_en, parity_type, irq}), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    data_out = 10'h033;
    apb_xfer(1'b0, 4'h8, 32'd0, 0, rd, err, ncyc, re_at);
    check_eq("post_rst_pop", rd, 32'h33);
    check_eq("post_rst_cyc", 32'(ncyc), 32'd2);

    repeat (2) @(posedge clk);
    check_eq("re_total", 32'(re_total), 32'd5);
    check_eq("re_consec", 32'(re_consec), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
